// File: rtl/kmul_feeder.sv
// kmul_feeder: stream wrapper around the pipelined 24->12 bit mod-q reducer.
// Accepts operand pairs, range-corrects each operand below Q, multiplies,
// drives the product to the reducer, follows each product through the
// reducer's fixed latency and queues the reduced result in an output FIFO.
// Admission is credit-based, so the non-stallable reducer can never
// overflow the FIFO.
//
// Ports:
//   clk, rst              clock (rising edge), synchronous active-high reset
//   in_valid/in_ready     operand-pair handshake; in_a, in_b are 12-bit operands
//   red_data              registered 24-bit product to the reducer
//   red_result            reducer output, valid RED_LAT edges after red_data
//   out_valid/out_ready   result handshake; out_coef = (in_a*in_b) mod Q
//   busy                  any item is in flight or queued
module kmul_feeder #(
  parameter int Q          = 3329,
  parameter int RED_LAT    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] in_a,
  input  logic [11:0] in_b,
  output logic [23:0] red_data,
  input  logic [11:0] red_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_coef,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [11:0]   QW      = 12'(Q);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [11:0]        a_s1, b_s1;
  logic               v_s1, v_s2;
  logic [RED_LAT-1:0] v_sh;
  logic [RED_LAT:0]   sh_ext;

  logic [11:0]   mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [CW-1:0] outstanding;

  logic accept, pop, fifo_wr;

  // Credit check uses only registered state (plus rst), never in_valid/out_ready.
  assign in_ready  = !rst && (outstanding < DEPTH_C);
  assign accept    = in_valid && in_ready;
  assign out_valid = (wr_ptr != rd_ptr);
  assign pop       = out_valid && out_ready;
  assign fifo_wr   = v_sh[RED_LAT-1];
  assign out_coef  = out_valid ? mem[rd_ptr[AW-1:0]] : '0;
  assign busy      = (outstanding != '0);

  // Valid bit enters the reducer-latency shift register at the bottom.
  assign sh_ext = {v_sh, v_s2};

  always_ff @(posedge clk) begin
    if (rst) begin
      a_s1     <= '0;
      b_s1     <= '0;
      v_s1     <= 1'b0;
      v_s2     <= 1'b0;
      red_data <= '0;
      v_sh     <= '0;
    end else begin
      v_s1 <= accept;
      if (accept) begin
        a_s1 <= (in_a >= QW) ? in_a - QW : in_a;
        b_s1 <= (in_b >= QW) ? in_b - QW : in_b;
      end
      v_s2 <= v_s1;
      if (v_s1) begin
        red_data <= {12'd0, a_s1} * {12'd0, b_s1};
      end
      v_sh <= sh_ext[RED_LAT-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      mem[wr_ptr[AW-1:0]] <= red_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
    end else begin
      if (fifo_wr) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + CNT_ONE;
        2'b01:   outstanding <= outstanding - CNT_ONE;
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_kmul_feeder.sv
// Bench for kmul_feeder: two instances (FIFO_DEPTH 4 and 8), each fed by a
// behavioural RED_LAT-stage reducer model. Inputs change on the falling edge,
// outputs are sampled on the falling edge.
module tb_kmul_feeder;

  localparam int Q  = 3329;
  localparam int RL = 4;
  localparam logic [23:0] MAXP = 24'd11075584;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        d4_in_valid = 1'b0, d4_in_ready, d4_out_valid, d4_out_ready = 1'b1, d4_busy;
  logic [11:0] d4_in_a = '0, d4_in_b = '0, d4_red_result, d4_out_coef;
  logic [23:0] d4_red_data;
  logic        d8_in_valid = 1'b0, d8_in_ready, d8_out_valid, d8_out_ready = 1'b1, d8_busy;
  logic [11:0] d8_in_a = '0, d8_in_b = '0, d8_red_result, d8_out_coef;
  logic [23:0] d8_red_data;

  kmul_feeder #(.Q(Q), .RED_LAT(RL), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(d4_in_valid), .in_ready(d4_in_ready),
    .in_a(d4_in_a), .in_b(d4_in_b), .red_data(d4_red_data), .red_result(d4_red_result),
    .out_valid(d4_out_valid), .out_ready(d4_out_ready), .out_coef(d4_out_coef), .busy(d4_busy)
  );

  kmul_feeder #(.Q(Q), .RED_LAT(RL), .FIFO_DEPTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(d8_in_valid), .in_ready(d8_in_ready),
    .in_a(d8_in_a), .in_b(d8_in_b), .red_data(d8_red_data), .red_result(d8_red_result),
    .out_valid(d8_out_valid), .out_ready(d8_out_ready), .out_coef(d8_out_coef), .busy(d8_busy)
  );

  // Reducer models: RL register stages, no stall, no reset.
  logic [11:0] d4_pipe [RL];
  logic [11:0] d8_pipe [RL];
  always @(posedge clk) begin
    d4_pipe[0] <= 12'(32'(d4_red_data) % Q);
    d8_pipe[0] <= 12'(32'(d8_red_data) % Q);
    for (int i = 1; i < RL; i++) begin
      d4_pipe[i] <= d4_pipe[i-1];
      d8_pipe[i] <= d8_pipe[i-1];
    end
  end
  assign d4_red_result = d4_pipe[RL-1];
  assign d8_red_result = d8_pipe[RL-1];

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (d4_red_data > MAXP || d8_red_data > MAXP) begin
        errors++;
        $display("FAIL red_data_range got %0d/%0d max %0d", d4_red_data, d8_red_data, MAXP);
      end
    end
  end

  function automatic logic [11:0] modmul(input logic [11:0] a, input logic [11:0] b);
    int unsigned p;
    p = 32'(a) * 32'(b);
    return 12'(p % Q);
  endfunction

  function automatic logic [11:0] rc(input logic [11:0] a);
    return (a >= 12'd3329) ? a - 12'd3329 : a;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (d4_in_ready !== 1'b0 || d8_in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b/%b exp 0", d4_in_ready, d8_in_ready); end
    checks++; if (d4_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", d4_busy); end
    checks++; if (d4_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", d4_out_valid); end
    checks++; if (d4_red_data !== 24'd0) begin errors++; $display("FAIL reset_red_data got %0d exp 0", d4_red_data); end
    checks++; if (d4_out_coef !== 12'd0) begin errors++; $display("FAIL reset_out_coef got %0d exp 0", d4_out_coef); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (d4_in_ready !== 1'b1 || d8_in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b/%b exp 1", d4_in_ready, d8_in_ready); end
  endtask

  task automatic test_single(input logic [11:0] a, input logic [11:0] b, input logic [11:0] exp, input string name);
    logic [23:0] ep;
    logic early;
    ep = {12'd0, rc(a)} * {12'd0, rc(b)};
    early = 1'b0;
    @(negedge clk);
    d4_out_ready = 1'b1;
    d4_in_valid = 1'b1; d4_in_a = a; d4_in_b = b;
    checks++; if (d4_in_ready !== 1'b1) begin errors++; $display("FAIL %s_ready got %b exp 1", name, d4_in_ready); end
    @(negedge clk);                       // after accept edge E0
    d4_in_valid = 1'b0;
    @(negedge clk);                       // after E1: product on red_data
    checks++; if (d4_red_data !== ep) begin errors++; $display("FAIL %s_red_data got %0d exp %0d", name, d4_red_data, ep); end
    if (d4_out_valid) early = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (d4_out_valid) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL %s_early got %b exp 0", name, early); end
    @(negedge clk);                       // after E0+RL+2
    checks++; if (d4_out_valid !== 1'b1) begin errors++; $display("FAIL %s_valid got %b exp 1", name, d4_out_valid); end
    checks++; if (d4_out_coef !== exp) begin errors++; $display("FAIL %s_coef got %0d exp %0d", name, d4_out_coef, exp); end
    @(negedge clk);
    checks++; if (d4_out_valid !== 1'b0 || d4_busy !== 1'b0) begin errors++; $display("FAIL %s_drain got valid %b busy %b exp 0 0", name, d4_out_valid, d4_busy); end
  endtask

  task automatic test_basic();
    test_single(12'd1,    12'd1,    12'd1,    "s_1_1");
    test_single(12'd17,   12'd17,   12'd289,  "s_17_17");
    test_single(12'd2000, 12'd2000, 12'd1871, "s_2000_2000");
    test_single(12'd3328, 12'd3328, 12'd1,    "s_3328_3328");
    test_single(12'd0,    12'd3328, 12'd0,    "s_0_3328");
  endtask

  task automatic test_range_correct();
    test_single(12'd4095, 12'd1,    12'd766,  "r_4095_1");
    test_single(12'd4095, 12'd2,    12'd1532, "r_4095_2");
    test_single(12'd3329, 12'd3329, 12'd0,    "r_3329_3329");
  endtask

  task automatic test_back_to_back();
    logic [11:0] xa [32];
    logic [11:0] xb [32];
    logic [11:0] xe [32];
    int got, first, last;
    for (int i = 0; i < 32; i++) begin
      xa[i] = 12'($urandom_range(0, 4095));
      xb[i] = 12'($urandom_range(0, 4095));
      xe[i] = modmul(rc(xa[i]), rc(xb[i]));
    end
    got = 0; first = -1; last = -1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      d8_out_ready = 1'b1;
      if (d8_out_valid) begin
        if (got < 32) begin
          checks++; if (d8_out_coef !== xe[got]) begin errors++; $display("FAIL b2b_coef[%0d] got %0d exp %0d", got, d8_out_coef, xe[got]); end
        end
        if (first < 0) first = c;
        last = c;
        got++;
      end
      if (c < 32) begin
        d8_in_valid = 1'b1; d8_in_a = xa[c]; d8_in_b = xb[c];
        checks++; if (d8_in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b exp 1", c, d8_in_ready); end
      end else begin
        d8_in_valid = 1'b0;
      end
    end
    checks++; if (got != 32) begin errors++; $display("FAIL b2b_count got %0d exp 32", got); end
    checks++; if (last - first != 31) begin errors++; $display("FAIL b2b_rate got span %0d exp 31", last - first); end
  endtask

  task automatic test_backpressure();
    logic [11:0] pa [6] = '{12'd100, 12'd3000, 12'd12, 12'd4000, 12'd1234, 12'd3328};
    logic [11:0] pb [6] = '{12'd200, 12'd3000, 12'd34, 12'd7,    12'd2,    12'd2};
    logic [11:0] pe [6] = '{12'd26,  12'd1713, 12'd408, 12'd1368, 12'd2468, 12'd3327};
    logic [11:0] head;
    int idx, got;
    idx = 0;
    d4_out_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (idx < 6) begin
        d4_in_valid = 1'b1; d4_in_a = pa[idx]; d4_in_b = pb[idx];
        if (d4_in_ready) idx++;
      end
    end
    checks++; if (idx != 4) begin errors++; $display("FAIL bp_accepted got %0d exp 4", idx); end
    checks++; if (d4_in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low got %b exp 0", d4_in_ready); end
    checks++; if (d4_busy !== 1'b1) begin errors++; $display("FAIL bp_busy got %b exp 1", d4_busy); end
    checks++; if (d4_out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b exp 1", d4_out_valid); end
    head = d4_out_coef;
    repeat (3) @(negedge clk);
    checks++; if (d4_out_coef !== head || head !== pe[0]) begin errors++; $display("FAIL bp_head_stable got %0d exp %0d", d4_out_coef, pe[0]); end
    got = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      d4_out_ready = 1'b1;
      if (d4_out_valid) begin
        checks++;
        if (got >= 6) begin errors++; $display("FAIL bp_extra got %0d exp none", d4_out_coef); end
        else if (d4_out_coef !== pe[got]) begin errors++; $display("FAIL bp_coef[%0d] got %0d exp %0d", got, d4_out_coef, pe[got]); end
        got++;
      end
      if (idx < 6) begin
        d4_in_valid = 1'b1; d4_in_a = pa[idx]; d4_in_b = pb[idx];
        if (d4_in_ready) idx++;
      end else begin
        d4_in_valid = 1'b0;
      end
    end
    checks++; if (got != 6 || idx != 6) begin errors++; $display("FAIL bp_total got %0d/%0d exp 6/6", got, idx); end
    checks++; if (d4_busy !== 1'b0 || d4_in_ready !== 1'b1) begin errors++; $display("FAIL bp_idle got busy %b ready %b exp 0 1", d4_busy, d4_in_ready); end
  endtask

  task automatic test_simultaneous();
    localparam int N = 24;
    logic [11:0] sa [N];
    logic [11:0] sb [N];
    logic [11:0] se [N];
    int acc, got;
    logic exp_ready;
    for (int i = 0; i < N; i++) begin
      sa[i] = 12'($urandom_range(0, 4095));
      sb[i] = 12'($urandom_range(0, 4095));
      se[i] = modmul(rc(sa[i]), rc(sb[i]));
    end
    acc = 0; got = 0;
    for (int c = 0; c < 400 && got < N; c++) begin
      @(negedge clk);
      exp_ready = ((acc - got) < 4);
      checks++; if (d4_in_ready !== exp_ready) begin errors++; $display("FAIL sim_credit c=%0d got %b exp %b", c, d4_in_ready, exp_ready); end
      d4_out_ready = (c < 12) ? 1'b0 : 1'($urandom_range(0, 1));
      if (d4_out_valid && d4_out_ready) begin
        checks++;
        if (got >= acc) begin errors++; $display("FAIL sim_dup got %0d exp none", d4_out_coef); end
        else if (d4_out_coef !== se[got]) begin errors++; $display("FAIL sim_coef[%0d] got %0d exp %0d", got, d4_out_coef, se[got]); end
        got++;
      end
      if (acc < N) begin
        d4_in_valid = 1'b1; d4_in_a = sa[acc]; d4_in_b = sb[acc];
        if (d4_in_ready) acc++;
      end else begin
        d4_in_valid = 1'b0;
      end
    end
    d4_in_valid = 1'b0;
    d4_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (got != N) begin errors++; $display("FAIL sim_count got %0d exp %0d", got, N); end
    checks++; if (d4_busy !== 1'b0 || d4_out_valid !== 1'b0) begin errors++; $display("FAIL sim_idle got busy %b valid %b exp 0 0", d4_busy, d4_out_valid); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] pat;
    logic stale, seen;
    pat = 8'b0111_0011;   // accepts on cycles 0,1,4,5,6
    d8_out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      d8_in_valid = pat[c]; d8_in_a = 12'(100 + c); d8_in_b = 12'(7 * c + 3);
      if (pat[c]) begin
        checks++; if (d8_in_ready !== 1'b1) begin errors++; $display("FAIL rm_ready[%0d] got %b exp 1", c, d8_in_ready); end
      end
    end
    @(negedge clk);       // 2 items queued, 3 in flight
    d8_in_valid = 1'b0;
    checks++; if (d8_out_valid !== 1'b1 || d8_busy !== 1'b1) begin errors++; $display("FAIL rm_pre got valid %b busy %b exp 1 1", d8_out_valid, d8_busy); end
    rst = 1'b1;
    #1;
    checks++; if (d8_in_ready !== 1'b0) begin errors++; $display("FAIL rm_ready_in_rst got %b exp 0", d8_in_ready); end
    @(negedge clk);
    rst = 1'b0;
    checks++; if (d8_out_valid !== 1'b0) begin errors++; $display("FAIL rm_out_valid got %b exp 0", d8_out_valid); end
    checks++; if (d8_busy !== 1'b0) begin errors++; $display("FAIL rm_busy got %b exp 0", d8_busy); end
    checks++; if (d8_red_data !== 24'd0) begin errors++; $display("FAIL rm_red_data got %0d exp 0", d8_red_data); end
    checks++; if (d8_out_coef !== 12'd0) begin errors++; $display("FAIL rm_out_coef got %0d exp 0", d8_out_coef); end
    #1;
    checks++; if (d8_in_ready !== 1'b1) begin errors++; $display("FAIL rm_in_ready got %b exp 1", d8_in_ready); end
    d8_out_ready = 1'b1;
    stale = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (d8_out_valid) stale = 1'b1;
    end
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL rm_stale got %b exp 0", stale); end
    @(negedge clk);
    d8_in_valid = 1'b1; d8_in_a = 12'd5; d8_in_b = 12'd7;
    @(negedge clk);
    d8_in_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 12 && !seen; c++) begin
      @(negedge clk);
      if (d8_out_valid) begin
        seen = 1'b1;
        checks++; if (d8_out_coef !== 12'd35) begin errors++; $display("FAIL rm_fresh_coef got %0d exp 35", d8_out_coef); end
      end
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rm_fresh_timeout got %b exp 1", seen); end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_range_correct();
    test_back_to_back();
    test_backpressure();
    test_simultaneous();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
